// File: rtl/showcase_result_pkg.sv
// Shared types and sizing helpers for the showcase result capture FIFO.
package showcase_result_pkg;

  localparam int CMP_W = 6;
  localparam int RESULT_DATA_WIDTH = 32;

  typedef struct packed {
    logic [CMP_W-1:0]             cmp;
    logic [RESULT_DATA_WIDTH-1:0] c;
  } showcase_result_t;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/showcase_result_mem.sv
// Storage array for the result FIFO: one synchronous write port, one asynchronous read port.
module showcase_result_mem #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read gives first-word-fall-through behaviour at the head.
  assign rdata = mem[raddr];

endmodule

// File: rtl/showcase_result_fifo.sv
// Capture FIFO for the showcase unit's sum and compare flags, with drop reporting.
// Optional saturating discard counter: define SHOWCASE_RESULT_FIFO_OVF_CNT_EN.
module showcase_result_fifo
  import showcase_result_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_vld,
  input  logic [DATA_WIDTH-1:0]       in_c,
  input  logic [CMP_W-1:0]            in_cmp,
  output logic [DATA_WIDTH+CMP_W-1:0] out_data,
  output logic                        out_vld,
  input  logic                        out_rd,
  output logic                        full,
  output logic [clog2_cnt(DEPTH)-1:0] count,
  output logic                        drop,
  output logic [CNT_WIDTH-1:0]        ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_cnt(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          drop_reg;
  logic          push;
  logic          pop;
  logic          discard;

  assign out_vld = (count_reg != '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign drop    = drop_reg;

  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign pop     = out_rd && out_vld;
  assign push    = in_vld && (!full || pop);
  assign discard = in_vld && !push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
      drop_reg  <= discard;
    end
  end

  showcase_result_mem #(
    .WIDTH (DATA_WIDTH + CMP_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && rst_n),
    .waddr (wr_ptr_reg),
    .wdata ({in_cmp, in_c}),
    .raddr (rd_ptr_reg),
    .rdata (out_data)
  );

`ifdef SHOWCASE_RESULT_FIFO_OVF_CNT_EN
  logic [CNT_WIDTH-1:0] ovf_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_reg <= '0;
    end else if (discard && (ovf_cnt_reg != '1)) begin
      ovf_cnt_reg <= ovf_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_showcase_result_fifo.sv
// Randomized and directed check of showcase_result_fifo against a queue-based reference model.
module tb_showcase_result_fifo;
  import showcase_result_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = clog2_cnt(DEPTH);
  localparam int OW    = DW + CMP_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic [DW-1:0] in_c;
  logic [5:0]    in_cmp;
  logic          out_rd;

  logic [OW-1:0] out_data, s_out_data;
  logic          out_vld, s_out_vld, full, s_full, drop, s_drop;
  logic [CW-1:0] count, s_count;
  logic [15:0]   ovf_cnt;
  logic [1:0]    s_ovf_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [OW-1:0] model_q[$];
  logic          exp_drop;
  int            exp_ovf;

  always #5 clk = ~clk;

  showcase_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_c(in_c), .in_cmp(in_cmp),
    .out_data(out_data), .out_vld(out_vld), .out_rd(out_rd), .full(full),
    .count(count), .drop(drop), .ovf_cnt(ovf_cnt)
  );

  showcase_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_c(in_c), .in_cmp(in_cmp),
    .out_data(s_out_data), .out_vld(s_out_vld), .out_rd(out_rd), .full(s_full),
    .count(s_count), .drop(s_drop), .ovf_cnt(s_ovf_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // One clock: drive, let the model apply the rules at the edge, then compare.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] c,
                      input logic [5:0] cmp, input logic rd);
    logic do_pop;
    logic room;
    int   exp_ovf_big;
    int   exp_ovf_sat;
    rst_n = r; in_vld = v; in_c = c; in_cmp = cmp; out_rd = rd;
    @(posedge clk);
    if (!r) begin
      model_q.delete();
      exp_drop = 1'b0;
      exp_ovf  = 0;
    end else begin
      do_pop = rd && (model_q.size() > 0);
      room   = (model_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(model_q.pop_front());
      if (v && room) model_q.push_back({cmp, c});
      exp_drop = v && !room;
      if (exp_drop) exp_ovf++;
    end
`ifdef SHOWCASE_RESULT_FIFO_OVF_CNT_EN
    exp_ovf_big = sat(exp_ovf, 65535);
    exp_ovf_sat = sat(exp_ovf, 3);
`else
    exp_ovf_big = 0;
    exp_ovf_sat = 0;
`endif
    #1;
    chk("count",   64'(count),     64'(model_q.size()));
    chk("out_vld", 64'(out_vld),   64'(model_q.size() != 0));
    chk("full",    64'(full),      64'(model_q.size() == DEPTH));
    chk("drop",    64'(drop),      64'(exp_drop));
    chk("ovf_cnt", 64'(ovf_cnt),   64'(exp_ovf_big));
    chk("ovf_sat", 64'(s_ovf_cnt), 64'(exp_ovf_sat));
    if (model_q.size() != 0) chk("out_data", 64'(out_data), 64'(model_q[0]));
    $display("t=%0t rst_n=%0b vld=%0b c=%h rd=%0b | count=%0d vld=%0b drop=%0b ovf=%0d",
             $time, r, v, c, rd, count, out_vld, drop, ovf_cnt);
  endtask

  initial begin
    showcase_result_t first;
    logic [DW-1:0] rc;
    exp_drop = 1'b0;
    exp_ovf  = 0;
    rst_n = 1'b0; in_vld = 1'b0; in_c = '0; in_cmp = '0; out_rd = 1'b0;

    step(0, 0, 0, 0, 0);
    step(0, 1, 32'hDEAD, 6'h3F, 0);
    chk("reset_vld", 64'(out_vld), 64'd0);

    // First capture is visible one cycle later in {cmp, c} order.
    first.cmp = 6'b010101;
    first.c   = 32'h0000_0007;
    step(1, 1, first.c, first.cmp, 0);
    chk("first_data", 64'(out_data), 64'(first));
    chk("first_count", 64'(count), 64'd1);
    step(1, 0, 0, 0, 1);

    for (int i = 1; i <= 4; i++) step(1, 1, DW'(i), 6'(i), 0);
    chk("fill_full", 64'(full), 64'd1);
    step(1, 1, 32'd5, 6'h05, 0);
    chk("drop_pulse", 64'(drop), 64'd1);
    step(1, 0, 0, 0, 0);
    chk("drop_clear", 64'(drop), 64'd0);

    step(1, 1, 32'd9, 6'h09, 1);
    chk("full_pushpop_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);

    step(1, 1, 32'hA, 6'h0A, 1);
    chk("empty_rd_head", 64'(out_data[DW-1:0]), 64'hA);
    step(1, 0, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      rc = $urandom;
      step(1, 1, rc, 6'($urandom), 0);
      step(1, 0, 0, 0, 1);
    end

    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 6'($urandom), 0);
    step(0, 1, 32'h1234, 6'h11, 0);
    chk("rst_count", 64'(count), 64'd0);

    for (int i = 0; i < 4; i++) step(1, 1, $urandom, 6'($urandom), 0);
    for (int i = 0; i < 5; i++) step(1, 1, $urandom, 6'($urandom), 0);
`ifdef SHOWCASE_RESULT_FIFO_OVF_CNT_EN
    chk("sat_ovf", 64'(s_ovf_cnt), 64'd3);
`else
    chk("sat_ovf", 64'(s_ovf_cnt), 64'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), $urandom,
           6'($urandom), ($urandom_range(0, 1) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
